fadd_seq: RTL and testbench

- Multi-cycle sequencer for single-precision IEEE-754 addition.
- Accepts two packed operands over a valid/ready handshake, then steps them through five phases: unpack/classify, exponent align, sign-magnitude add, normalize, round/pack.
- Drives the internal 27-bit sign-magnitude adder datapath one phase per cycle.
- Sits between the operand register file and the result writeback path of the float unit.

---
 rtl/fadd_pkg.sv | 51 +++++
 rtl/fadd_lzc.sv | 18 +
 rtl/fadd_seq.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fadd_seq.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fadd_pkg.sv
// Shared types and constants for the sequential single-precision adder.
// Holds the FSM state enum, operand classes and the datapath widths.
package fadd_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MAG_W    = 27;
  localparam int unsigned SUM_W    = 28;
  localparam int unsigned LZC_W    = 5;
  localparam int unsigned EXPI_W   = 10;

  localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    DONE
  } fadd_state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } op_class_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Denormals classify as zero so they are flushed on entry.
  function automatic op_class_e classify(input fp32_t op);
    op_class_e cls;
    if (op.exp == '0) begin
      cls = CLS_ZERO;
    end else if (op.exp == EXP_W'(EXP_MAX)) begin
      cls = (op.frac != '0) ? CLS_NAN : CLS_INF;
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fadd_lzc.sv
// Combinational leading-zero counter over the 28-bit adder sum.
// An all-zero input reports the full width (28).
module fadd_lzc
  import fadd_pkg::*;
(
  input  logic [SUM_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    count = LZC_W'(SUM_W);
    for (int i = 0; i < int'(SUM_W); i++) begin
      if (value[i]) count = LZC_W'(int'(SUM_W) - 1 - i);
    end
  end

endmodule

// File: rtl/fadd_seq.sv
// Multi-cycle IEEE-754 single-precision adder: unpack, align, add, normalize, round.
// Define FADD_SEQ_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags output.
module fadd_seq
  import fadd_pkg::*;
#(
  parameter logic [31:0] QNAN = QNAN_DEFAULT
) (
  input  logic        clk,
  input  logic        res,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
`ifdef FADD_SEQ_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  fadd_state_e state_q, state_d;

  logic              sx_q, sx_d, sy_q, sy_d, sign_q, sign_d;
  logic [EXP_W-1:0]  ex_q, ex_d, ey_q, ey_d;
  logic [MAG_W-1:0]  mx_q, mx_d, my_q, my_d, mant_q, mant_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic signed [EXPI_W-1:0] exp_q, exp_d;
  logic [31:0]       result_d;
  logic              in_ready_d, out_valid_d, busy_d;
`ifdef FADD_SEQ_FLAGS_EN
  logic [3:0]        flags_d;
`endif

  // Operand unpack and classification
  fp32_t     op_a, op_b;
  op_class_e cls_a, cls_b;

  assign op_a  = fp32_t'(a);
  assign op_b  = fp32_t'(b);
  assign cls_a = classify(op_a);
  assign cls_b = classify(op_b);

  // Alignment: larger magnitude becomes X, Y shifted right with sticky
  logic             swap_c, far_c;
  logic             big_s_c, small_s_c;
  logic [EXP_W-1:0] big_e_c, small_e_c, dist_c;
  logic [MAG_W-1:0] big_m_c, small_m_c, lost_c, small_sh_c;
  logic [LZC_W-1:0] shamt_c;

  assign swap_c     = {ey_q, my_q} > {ex_q, mx_q};
  assign big_s_c    = swap_c ? sy_q : sx_q;
  assign small_s_c  = swap_c ? sx_q : sy_q;
  assign big_e_c    = swap_c ? ey_q : ex_q;
  assign small_e_c  = swap_c ? ex_q : ey_q;
  assign big_m_c    = swap_c ? my_q : mx_q;
  assign small_m_c  = swap_c ? mx_q : my_q;
  assign dist_c     = big_e_c - small_e_c;
  assign far_c      = dist_c >= EXP_W'(MAG_W);
  assign shamt_c    = dist_c[LZC_W-1:0];
  assign lost_c     = small_m_c & ~({MAG_W{1'b1}} << shamt_c);
  assign small_sh_c = far_c ? {{(MAG_W-1){1'b0}}, |small_m_c}
                            : ((small_m_c >> shamt_c) | {{(MAG_W-1){1'b0}}, |lost_c});

  // Sign-magnitude add; after the swap a subtraction never goes negative
  logic [SUM_W-1:0] sum_c;

  assign sum_c = (sx_q == sy_q) ? ({1'b0, mx_q} + {1'b0, my_q})
                                : ({1'b0, mx_q} - {1'b0, my_q});

  // Normalize: place the leading one at bit 27 of the sum, keep the lost bit as sticky
  logic [LZC_W-1:0]         lzc_c;
  logic [SUM_W-1:0]         shifted_c;
  logic [MAG_W-1:0]         norm_mant_c;
  logic signed [EXPI_W-1:0] norm_exp_c;

  fadd_lzc u_lzc (
    .value (sum_q),
    .count (lzc_c)
  );

  assign shifted_c   = sum_q << lzc_c;
  assign norm_mant_c = shifted_c[SUM_W-1:1] | {{(MAG_W-1){1'b0}}, shifted_c[0]};
  assign norm_exp_c  = exp_q + 10'sd1 - $signed({5'b0, lzc_c});

  // Round to nearest even on guard/round/sticky
  logic                     g_c, r_c, s_c, round_up_c, ovf_c;
  logic [FRAC_W+1:0]        rnd_c;
  logic [FRAC_W-1:0]        rnd_frac_c;
  logic signed [EXPI_W-1:0] rnd_exp_c;

  assign g_c        = mant_q[2];
  assign r_c        = mant_q[1];
  assign s_c        = mant_q[0];
  assign round_up_c = g_c & (r_c | s_c | mant_q[3]);
  assign rnd_c      = {1'b0, mant_q[MAG_W-1:3]} + {{(FRAC_W+1){1'b0}}, round_up_c};
  assign rnd_exp_c  = exp_q + $signed({9'b0, rnd_c[FRAC_W+1]});
  assign rnd_frac_c = rnd_c[FRAC_W+1] ? rnd_c[FRAC_W:1] : rnd_c[FRAC_W-1:0];
  assign ovf_c      = rnd_exp_c >= $signed(EXPI_W'(EXP_MAX));

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    ex_d     = ex_q;
    ey_d     = ey_q;
    mx_d     = mx_q;
    my_d     = my_q;
    sum_d    = sum_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result;
`ifdef FADD_SEQ_FLAGS_EN
    flags_d  = flags;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          sx_d    = op_a.sign;
          ex_d    = op_a.exp;
          mx_d    = {1'b1, op_a.frac, 3'b000};
          sy_d    = op_b.sign;
          ey_d    = op_b.exp;
          my_d    = {1'b1, op_b.frac, 3'b000};
          state_d = DONE;
`ifdef FADD_SEQ_FLAGS_EN
          flags_d = 4'b0000;
`endif
          if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            result_d = QNAN;
`ifdef FADD_SEQ_FLAGS_EN
            flags_d  = 4'b1000;
`endif
          end else if (cls_a == CLS_INF && cls_b == CLS_INF) begin
            result_d = (op_a.sign != op_b.sign) ? QNAN : a;
`ifdef FADD_SEQ_FLAGS_EN
            flags_d  = (op_a.sign != op_b.sign) ? 4'b1000 : 4'b0000;
`endif
          end else if (cls_a == CLS_INF) begin
            result_d = a;
          end else if (cls_b == CLS_INF) begin
            result_d = b;
          end else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO) begin
            result_d = {op_a.sign & op_b.sign, 31'b0};
          end else if (cls_a == CLS_ZERO) begin
            result_d = b;
          end else if (cls_b == CLS_ZERO) begin
            result_d = a;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        sx_d    = big_s_c;
        sy_d    = small_s_c;
        ex_d    = big_e_c;
        ey_d    = small_e_c;
        mx_d    = big_m_c;
        my_d    = small_sh_c;
        state_d = ADD;
      end

      ADD: begin
        sum_d  = sum_c;
        sign_d = sx_q;
        exp_d  = $signed({2'b00, ex_q});
        if (sum_c == '0) begin
          result_d = 32'h0000_0000;
          state_d  = DONE;
        end else begin
          state_d  = NORM;
        end
      end

      NORM: begin
        mant_d = norm_mant_c;
        exp_d  = norm_exp_c;
        if (norm_exp_c <= 10'sd0) begin
          result_d = {sign_q, 31'b0};
          state_d  = DONE;
`ifdef FADD_SEQ_FLAGS_EN
          flags_d  = 4'b0011;
`endif
        end else begin
          state_d  = ROUND;
        end
      end

      ROUND: begin
        state_d = DONE;
        if (ovf_c) begin
          result_d = {sign_q, 8'hFF, 23'b0};
`ifdef FADD_SEQ_FLAGS_EN
          flags_d  = 4'b0101;
`endif
        end else begin
          result_d = {sign_q, rnd_exp_c[EXP_W-1:0], rnd_frac_c};
`ifdef FADD_SEQ_FLAGS_EN
          flags_d  = {3'b000, g_c | r_c | s_c};
`endif
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      sx_q      <= 1'b0;
      sy_q      <= 1'b0;
      ex_q      <= '0;
      ey_q      <= '0;
      mx_q      <= '0;
      my_q      <= '0;
      sum_q     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef FADD_SEQ_FLAGS_EN
      flags     <= 4'b0000;
`endif
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ex_q      <= ex_d;
      ey_q      <= ey_d;
      mx_q      <= mx_d;
      my_q      <= my_d;
      sum_q     <= sum_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      result    <= result_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      busy      <= busy_d;
`ifdef FADD_SEQ_FLAGS_EN
      flags     <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fadd_seq.sv
// Directed self-checking bench for fadd_seq with hand-computed IEEE-754 sums.
// Latency is counted in clock edges including the accept edge.
module tb_fadd_seq;

  logic        clk = 1'b0;
  logic        res;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;
`ifdef FADD_SEQ_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  fadd_seq dut (
    .clk       (clk),
    .res       (res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
`ifdef FADD_SEQ_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One operation: accept, wait bounded for out_valid, check result, latency, busy and flags.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] exp_res, input int exp_lat, input logic [3:0] exp_flags);
    int   w;
    int   lat;
    logic busy_ok;
    w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = av;
    b = bv;
    step();
    in_valid = 1'b0;
    a = 32'h0;
    b = 32'h0;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 20) begin
      if (!busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":result"}, result, exp_res);
    chk({tag, ":busy"}, 32'(busy_ok), 32'd1);
`ifdef FADD_SEQ_FLAGS_EN
    chk({tag, ":flags"}, 32'(flags), 32'(exp_flags));
`else
    if (exp_flags === 4'bxxxx) $display("note %s", tag);
`endif
    if (out_ready) step();
  endtask

  initial begin
    res       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'h0;
    b         = 32'h0;
    step();
    step();
    chk("rst:in_ready", 32'(in_ready), 32'd1);
    chk("rst:out_valid", 32'(out_valid), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:result", result, 32'h0);
`ifdef FADD_SEQ_FLAGS_EN
    chk("rst:flags", 32'(flags), 32'd0);
`endif
    res = 1'b0;
    step();

    // Normal, cancelling and special-case sums
    do_op("one_plus_two", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 4'b0000);
    do_op("one_minus_one", 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 3, 4'b0000);
    do_op("negz_negz", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1, 4'b0000);
    do_op("posz_negz", 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1, 4'b0000);
    do_op("denorm_flush", 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1, 4'b0000);
    do_op("zero_plus_x", 32'h0000_0000, 32'h3FC0_0000, 32'h3FC0_0000, 1, 4'b0000);
    do_op("tie_even", 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 5, 4'b0001);
    do_op("round_up", 32'h3F80_0000, 32'h3380_0001, 32'h3F80_0001, 5, 4'b0001);
    do_op("round_carry", 32'h3FFF_FFFF, 32'h3380_0000, 32'h4000_0000, 5, 4'b0001);
    do_op("far_sticky", 32'h3F80_0000, 32'h0D80_0000, 32'h3F80_0000, 5, 4'b0001);
    do_op("sub_norm", 32'h4000_0000, 32'hBFC0_0000, 32'h3F00_0000, 5, 4'b0000);
    do_op("overflow", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 5, 4'b0101);
    do_op("underflow", 32'h0080_0000, 32'h8080_0001, 32'h8000_0000, 4, 4'b0011);
    do_op("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1, 4'b1000);
    do_op("nan_in", 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, 4'b1000);
    do_op("inf_plus_fin", 32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 1, 4'b0000);

    // Back-pressure: result held, in_valid pulses ignored
    out_ready = 1'b0;
    do_op("bp", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a = 32'h3F80_0000;
      b = 32'h3F80_0000;
      step();
      chk("bp:hold_result", result, 32'h4040_0000);
      chk("bp:in_ready", 32'(in_ready), 32'd0);
      chk("bp:out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp:release_valid", 32'(out_valid), 32'd0);
    chk("bp:release_ready", 32'(in_ready), 32'd1);
    chk("bp:release_busy", 32'(busy), 32'd0);
    do_op("after_bp", 32'h4000_0000, 32'hBFC0_0000, 32'h3F00_0000, 5, 4'b0000);

    // Leave nonzero flags behind, then reset asynchronously in the ADD state
    do_op("pre_reset", 32'h3FFF_FFFF, 32'h3380_0000, 32'h4000_0000, 5, 4'b0001);
    in_valid = 1'b1;
    a = 32'h3F80_0000;
    b = 32'h4000_0000;
    step();
    in_valid = 1'b0;
    step();
    #2;
    res = 1'b1;
    #1;
    chk("async:in_ready", 32'(in_ready), 32'd1);
    chk("async:out_valid", 32'(out_valid), 32'd0);
    chk("async:busy", 32'(busy), 32'd0);
    chk("async:result", result, 32'h0);
`ifdef FADD_SEQ_FLAGS_EN
    chk("async:flags", 32'(flags), 32'd0);
`endif
    #2;
    res = 1'b0;
    step();
    do_op("post_reset", 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
